// File: rtl/fft_reorder_if.sv
// Sample streams around the FFT reorder buffer: FFT-order input and natural-order output.
// master drives the FFT-order samples, slave is the reorder block.
interface fft_reorder_if #(
   parameter int LOG2N = 5,
   parameter int DW    = 17
);
   logic                    in_valid;
   logic signed [DW-1:0]    Y_re;
   logic signed [DW-1:0]    Y_im;
   logic                    out_valid;
   logic signed [DW-1:0]    out_re;
   logic signed [DW-1:0]    out_im;
   logic        [LOG2N-1:0] out_index;
   logic                    frame_start;

   modport master (
      output in_valid, Y_re, Y_im,
      input  out_valid, out_re, out_im, out_index, frame_start
   );

   modport slave (
      input  in_valid, Y_re, Y_im,
      output out_valid, out_re, out_im, out_index, frame_start
   );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong frame buffer that turns FFT-order samples into natural bin order.
// Macro FFT_REORDER_BITREV_EN enables bit-reversed write addressing; undefined gives a pure frame delay.
module fft_reorder #(
   parameter int N     = 32,
   parameter int LOG2N = 5,
   parameter int DW    = 17
) (
   input  logic          Clk,
   input  logic          Reset,
   fft_reorder_if.slave  bus
);

   typedef enum logic {IDLE, READ} state_t;

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   state_t               state;
   logic [LOG2N-1:0]     wcnt;
   logic                 wbank;
   logic [1:0]           full;
   logic [1:0]           full_set;
   logic [1:0]           full_clr;
   logic [LOG2N-1:0]     waddr_p0;
   logic [LOG2N-1:0]     raddr_p1;
   logic                 rbank_p1;
   logic [2*DW-1:0]      mem [2*N];
   logic [2*DW-1:0]      rdata_p1;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   // Write stage: sample lands at its final bin position
   always_comb begin
`ifdef FFT_REORDER_BITREV_EN
      waddr_p0 = bitrev(wcnt);
`else
      waddr_p0 = wcnt;
`endif
   end

   always_ff @(posedge Clk) begin
      if (bus.in_valid) mem[{wbank, waddr_p0}] <= {bus.Y_re, bus.Y_im};
   end

   // A bank completing and a bank draining never coincide, so set simply wins.
   always_comb begin
      full_set = '0;
      full_clr = '0;
      if (bus.in_valid && wcnt == LAST) full_set[wbank]    = 1'b1;
      if (state == READ && raddr_p1 == LAST) full_clr[rbank_p1] = 1'b1;
   end

   assign rdata_p1 = mem[{rbank_p1, raddr_p1}];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wcnt     <= '0;
         wbank    <= 1'b0;
         full     <= '0;
         state    <= IDLE;
         raddr_p1 <= '0;
         rbank_p1 <= 1'b0;
      end else begin
         full <= (full & ~full_clr) | full_set;
         if (bus.in_valid) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == LAST) wbank <= ~wbank;
         end
         // Read-issue stage: one address per cycle, banks drained alternately
         case (state)
            IDLE: begin
               if (full[rbank_p1]) begin
                  state    <= READ;
                  raddr_p1 <= '0;
               end
            end
            READ: begin
               if (raddr_p1 == LAST) begin
                  rbank_p1 <= ~rbank_p1;
                  raddr_p1 <= '0;
                  state    <= full[~rbank_p1] ? READ : IDLE;
               end else begin
                  raddr_p1 <= raddr_p1 + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output stage: registered data, index and frame marker
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.out_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.out_index   <= '0;
         bus.out_re      <= '0;
         bus.out_im      <= '0;
      end else begin
         bus.out_valid   <= (state == READ);
         bus.frame_start <= (state == READ) && (raddr_p1 == '0);
         bus.out_index   <= raddr_p1;
         if (state == READ) begin
            bus.out_re <= rdata_p1[2*DW-1:DW];
            bus.out_im <= rdata_p1[DW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: frames pushed as expected bins on input, popped on output.
module tb_fft_reorder;
   localparam int N     = 32;
   localparam int LOG2N = 5;
   localparam int DW    = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_reorder_if #(.LOG2N(LOG2N), .DW(DW)) bus();
   fft_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (.Clk(clk), .Reset(rst), .bus(bus));

   typedef struct { int idx; int re; int im; } exp_t;
   exp_t sb[$];

   int checks = 0, errors = 0;
   int fre[N], fim[N];
   int fcnt = 0;
   int edge_cnt = 0, done_edge = 0;
   int run_len = 0, last_run = 0, runs_done = 0, fs_cnt = 0, last_fs = 0;
   logic prev_vld = 1'b0;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int bitrev(input int a);
      int r = 0;
      for (int i = 0; i < LOG2N; i++) r |= ((a >> i) & 1) << (LOG2N - 1 - i);
      return r;
   endfunction

   function automatic int rnd();
      return int'($urandom_range(0, 131071)) - 65536;
   endfunction

   task automatic send(input int re, input int im);
      logic [31:0] vr, vi;
      vr = re; vi = im;
      bus.in_valid = 1'b1;
      bus.Y_re = vr[DW-1:0];
      bus.Y_im = vi[DW-1:0];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      fre[fcnt] = re; fim[fcnt] = im;
      fcnt++;
      if (fcnt == N) begin
         for (int j = 0; j < N; j++) begin
            int src;
`ifdef FFT_REORDER_BITREV_EN
            src = bitrev(j);
`else
            src = j;
`endif
            sb.push_back('{j, fre[src], fim[src]});
         end
         done_edge = edge_cnt;
         fcnt = 0;
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_run(input int exp_len, input int exp_fs);
      int r0 = runs_done;
      int t = 0;
      while (runs_done == r0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk("run_seen", runs_done != r0, 1);
      chk("run_len", last_run, exp_len);
      chk("frame_start_count", last_fs, exp_fs);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.out_valid) begin
            if (!prev_vld) chk("latency", edge_cnt - done_edge, 2);
            run_len++;
            if (bus.frame_start) fs_cnt++;
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("out_index", bus.out_index, e.idx);
               chk("out_re", bus.out_re, e.re);
               chk("out_im", bus.out_im, e.im);
               chk("frame_start", bus.frame_start, e.idx == 0);
            end
         end else if (prev_vld) begin
            last_run = run_len;
            last_fs = fs_cnt;
            run_len = 0;
            fs_cnt = 0;
            runs_done++;
         end
         prev_vld = bus.out_valid;
      end else begin
         prev_vld = 1'b0;
         run_len = 0;
         fs_cnt = 0;
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.Y_re = '0;
      bus.Y_im = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_frame_start", bus.frame_start, 0);
      chk("rst_out_index", bus.out_index, 0);
      chk("rst_out_re", bus.out_re, 0);
      chk("rst_out_im", bus.out_im, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // ramp frame, no gaps
      for (int k = 0; k < N; k++) send(k, -k);
      wait_run(N, 1);

      // same frame with in_valid low every other cycle
      for (int k = 0; k < N; k++) begin
         send(k, -k);
         idle(1);
      end
      wait_run(N, 1);

      // two back-to-back frames of random data
      for (int k = 0; k < 2 * N; k++) send(rnd(), rnd());
      wait_run(2 * N, 2);

      // partial frame discarded by a one-cycle reset
      for (int k = 0; k < 10; k++) send(1000 + k, -1000 - k);
      rst = 1'b1;
      fcnt = 0;
      @(posedge clk); #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      for (int k = 0; k < N; k++) send(200 + 3 * k, 7 * k - 50);
      wait_run(N, 1);

      // full-scale extremes, random gaps
      send(-65536, 65535);
      for (int k = 1; k < N; k++) begin
         send((k == 5) ? 65535 : rnd(), (k == 9) ? -65536 : rnd());
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      wait_run(N, 1);

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
